// File: rtl/three_phase_deadtime.sv
`default_nettype none
// ============================================================================
// Module      : three_phase_deadtime
// Description : Per-phase dead-time insertion producing non-overlapping
//               high/low gate drives. DEADTIME_FAULT_EN adds a latched
//               shoot-through check on the pwm_in / pwm_comp_in pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module three_phase_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic [2:0]          pwm_in,
  input  logic [2:0]          pwm_comp_in,
  output logic [2:0]          hs_out,
  output logic [2:0]          ls_out,
  output logic [2:0]          dt_active,
  output logic                fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_HS_ON = 2'd2,
    ST_LS_ON = 2'd3
  } state_t;

  logic w_force_idle;

`ifdef DEADTIME_FAULT_EN
  logic [2:0] w_incons;
  logic [2:0] r_incons;
  logic       w_fault_set;
  logic       r_fault;

  assign w_incons    = ~(pwm_in ^ pwm_comp_in);
  // Only the same phase inconsistent on two consecutive edges is a fault
  assign w_fault_set = |(w_incons & r_incons);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_incons <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_incons <= w_incons;
      if (!en)
        r_fault <= 1'b0;
      else if (w_fault_set)
        r_fault <= 1'b1;
    end
  end

  assign fault        = r_fault;
  // Including the set term drops the drives on the same edge the fault latches
  assign w_force_idle = !en || r_fault || w_fault_set;
`else
  logic w_unused_comp;

  assign w_unused_comp = ^pwm_comp_in;
  assign fault         = 1'b0;
  assign w_force_idle  = !en;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_phase
    state_t              r_state;
    state_t              w_next;
    logic [DT_WIDTH-1:0] r_cnt;
    logic                r_hs;
    logic                r_ls;
    logic                r_dt;

    always_comb begin
      w_next = r_state;
      if (w_force_idle) begin
        w_next = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:  w_next = ST_DEAD;
          ST_HS_ON: if (!pwm_in[g]) w_next = ST_DEAD;
          ST_LS_ON: if (pwm_in[g])  w_next = ST_DEAD;
          ST_DEAD:  if (r_cnt == '0) w_next = pwm_in[g] ? ST_HS_ON : ST_LS_ON;
          default:  w_next = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_hs    <= 1'b0;
        r_ls    <= 1'b0;
        r_dt    <= 1'b0;
      end else begin
        r_state <= w_next;
        r_hs    <= (w_next == ST_HS_ON);
        r_ls    <= (w_next == ST_LS_ON);
        r_dt    <= (w_next == ST_DEAD);
        // dead_time is captured only on band entry; counts down to 0 without wrap
        if (w_next == ST_DEAD) begin
          if (r_state != ST_DEAD)
            r_cnt <= dead_time;
          else
            r_cnt <= r_cnt - 1'b1;
        end
      end
    end

    assign hs_out[g]    = r_hs;
    assign ls_out[g]    = r_ls;
    assign dt_active[g] = r_dt;
  end

endmodule
`default_nettype wire
